snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
Snake body/motion engine. It sits on the opposite side of the game-state FSM: it consumes `game_state` and the direction buttons, and produces the `hit_boundary` and `hit_self` collision signals the FSM reacts to. It holds the snake segment list in a shift buffer and advances the snake on an internal move tick. It also answers per-cell occupancy queries from the VGA renderer.

Parameters:
- GRID_W, 40, grid width in cells; x range 0..GRID_W-1
- GRID_H, 30, grid height in cells; y range 0..GRID_H-1
- X_W, 6, x coordinate width
- Y_W, 5, y coordinate width
- MAX_LEN, 16, segment buffer depth
- LEN_W, 5, length counter width; must hold MAX_LEN
- INIT_LEN, 3, length after INITIAL
- MOVE_DIV, 12_500_000, clk cycles per move (8 moves/s at 100 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- game_state  in  2  00 RUNNING, 01 DIE, 10 INITIAL, 11 treated as DIE
- up / down / left / right  in  1 each  level direction buttons
- grow  in  1  one-cycle pulse; food eaten
- query_x  in  X_W  renderer cell x
- query_y  in  Y_W  renderer cell y
- query_body  out  1  combinational; query cell is occupied by segment 0..length-1
- query_head  out  1  combinational; query cell equals segment 0
- head_x  out  X_W  segment 0 x
- head_y  out  Y_W  segment 0 y
- length  out  LEN_W  current segment count
- move_tick  out  1  one-cycle pulse on each move evaluation
- hit_boundary  out  1  sticky collision with grid edge
- hit_self  out  1  sticky collision with own body

Behaviour:
- Reset (async, rst_n=0) and every cycle with game_state=INITIAL load the same layout:
  - seg[i] = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN
  - length = INIT_LEN; committed and pending direction = RIGHT
  - move counter = 0; grow_pending = 0
  - hit_boundary = hit_self = move_tick = 0
- Direction input, sampled every cycle in INITIAL and RUNNING:
  - Priority up > down > left > right.
  - A request opposite to the committed direction is ignored.
  - A valid request overwrites pending_dir.
  - The committed direction is updated from pending_dir only at a move.
- grow pulse: sets grow_pending in any state except INITIAL. It is cleared when a successful move consumes it.
- RUNNING, move counter:
  - Counts 0..MOVE_DIV-1.
  - At MOVE_DIV-1 it wraps to 0, move_tick=1 for that one cycle, and a move evaluation is performed in the same cycle.
- Move evaluation, next head = seg[0] + pending_dir:
  - Boundary: moving left at x=0, right at x=GRID_W-1, up at y=0, or down at y=GRID_H-1 sets hit_boundary=1. No shift.
  - Self: next head equals seg[i] for any i < length. Exclude i=length-1 when grow_pending=0, because the tail vacates that cell. A match sets hit_self=1. No shift.
  - Boundary takes precedence; both flags are never set by the same move.
  - Otherwise shift: seg[i] <= seg[i-1], seg[0] <= next head.
    - If grow_pending, length <= min(length+1, MAX_LEN) and grow_pending <= 0.
    - At MAX_LEN, grow is consumed without lengthening.
- DIE or 11: counter, segments, length and flags are frozen; flags stay asserted until INITIAL.
- RUNNING after a hit: no further moves while the flag is set; the counter is frozen.
- Outputs:
  - head_x, head_y and length are registered.
  - query outputs are combinational over the buffer.
  - Segments at index >= length are don't-care and never reported.

Test Plan:
1. Reset with rst_n=0 mid-run -> head=(20,15), seg1=(19,15), seg2=(18,15), length=3, all flags 0 immediately, without waiting for a clock edge.
2. MOVE_DIV=4, RUNNING, no buttons -> move_tick every 4th cycle; head_x goes 21, 22, 23; query at (18,15) returns 0 after the first move.
3. While moving RIGHT, press left -> ignored, head_x keeps incrementing. Then pulse up for 1 cycle -> next move gives head=(x,14).
4. Run right to x=39, next tick -> hit_boundary=1 and head stays (39,15). Hold DIE 10 cycles: outputs frozen. game_state=INITIAL -> layout restored, flag 0.
5. Grow to length 5, then steer up, left, down on successive ticks -> hit_self=1 on the down move. Separately, length 4 circling a 2x2 square -> no hit (tail exclusion).
6. grow pulsed 20 times with moves -> length saturates at 16; grow pulsed in DIE -> lengthens on the first move after re-entry only if not INITIAL-cleared.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine
//   Snake body and motion engine. Holds the segment list in a shift buffer,
//   advances the snake once every MOVE_DIV clocks while the game runs, and
//   reports edge and self collisions back to the game-state FSM. It also
//   answers per-cell occupancy queries from the renderer.
//
//   game_state | meaning
//   -----------+--------------------------------------------------------
//   00         | RUNNING: count, sample buttons, move on terminal count
//   01, 11     | DIE: everything frozen, grow may still be latched
//   10         | INITIAL: layout reloaded every cycle, flags cleared
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   game_state [1:0]      mode from the game FSM (table above)
//   up/down/left/right    level direction buttons (priority in that order)
//   grow                  one-cycle pulse, food eaten
//   query_x, query_y      renderer cell under test
//   query_body            cell holds any live segment (combinational)
//   query_head            cell holds segment 0 (combinational)
//   head_x, head_y        segment 0 coordinates
//   length                live segment count
//   move_tick             one-cycle pulse after every move evaluation
//   hit_boundary          sticky: last evaluated move left the grid
//   hit_self              sticky: last evaluated move ran into the body
module snake_engine #(
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30,
   parameter int X_W      = 6,
   parameter int Y_W      = 5,
   parameter int MAX_LEN  = 16,
   parameter int LEN_W    = 5,
   parameter int INIT_LEN = 3,
   parameter int MOVE_DIV = 12_500_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       game_state,
   input  logic             up,
   input  logic             down,
   input  logic             left,
   input  logic             right,
   input  logic             grow,
   input  logic [X_W-1:0]   query_x,
   input  logic [Y_W-1:0]   query_y,
   output logic             query_body,
   output logic             query_head,
   output logic [X_W-1:0]   head_x,
   output logic [Y_W-1:0]   head_y,
   output logic [LEN_W-1:0] length,
   output logic             move_tick,
   output logic             hit_boundary,
   output logic             hit_self
);

   localparam int              CNT_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
   localparam logic [X_W-1:0]   X_LAST   = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(GRID_H - 1);
   localparam logic [Y_W-1:0]   Y_START  = Y_W'(GRID_H / 2);

   localparam logic [1:0] GS_RUNNING = 2'b00;
   localparam logic [1:0] GS_INITIAL = 2'b10;

   // Opposite directions differ only in bit 0.
   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_t;

   logic [X_W-1:0]   seg_x [MAX_LEN];
   logic [Y_W-1:0]   seg_y [MAX_LEN];
   logic [CNT_W-1:0] move_cnt;
   dir_t             dir;
   dir_t             pending_dir;
   logic             grow_pending;

   logic             is_initial;
   logic             is_running;
   dir_t             base_dir;
   dir_t             req_dir;
   logic             req_valid;
   logic [X_W-1:0]   nxt_x;
   logic [Y_W-1:0]   nxt_y;
   logic             edge_hit;
   logic             body_hit;
   logic             move_now;

   function automatic logic [X_W-1:0] init_x(input int i);
      return (i < INIT_LEN) ? X_W'(GRID_W / 2 - i) : '0;
   endfunction

   function automatic logic [Y_W-1:0] init_y(input int i);
      return (i < INIT_LEN) ? Y_START : '0;
   endfunction

   assign is_initial = (game_state == GS_INITIAL);
   assign is_running = (game_state == GS_RUNNING);

   // In INITIAL the committed direction is being forced to RIGHT this very
   // cycle, so requests are judged against that instead of the stale value.
   assign base_dir = is_initial ? DIR_RIGHT : dir;

   always_comb begin
      req_dir   = DIR_RIGHT;
      req_valid = 1'b1;
      if (up)         req_dir = DIR_UP;
      else if (down)  req_dir = DIR_DOWN;
      else if (left)  req_dir = DIR_LEFT;
      else if (right) req_dir = DIR_RIGHT;
      else            req_valid = 1'b0;
      if (req_dir == dir_t'(base_dir ^ 2'b01))
         req_valid = 1'b0;
   end

   always_comb begin
      nxt_x    = seg_x[0];
      nxt_y    = seg_y[0];
      edge_hit = 1'b0;
      case (pending_dir)
         DIR_RIGHT: begin
            edge_hit = (seg_x[0] == X_LAST);
            nxt_x    = seg_x[0] + 1'b1;
         end
         DIR_LEFT: begin
            edge_hit = (seg_x[0] == '0);
            nxt_x    = seg_x[0] - 1'b1;
         end
         DIR_UP: begin
            edge_hit = (seg_y[0] == '0);
            nxt_y    = seg_y[0] - 1'b1;
         end
         default: begin
            edge_hit = (seg_y[0] == Y_LAST);
            nxt_y    = seg_y[0] + 1'b1;
         end
      endcase
   end

   // Without a pending grow the tail moves out of its cell on this same
   // move, so stepping into it is legal.
   always_comb begin
      body_hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < length) &&
             !(!grow_pending && (LEN_W'(i) == length - 1'b1)) &&
             (seg_x[i] == nxt_x) && (seg_y[i] == nxt_y))
            body_hit = 1'b1;
      end
   end

   always_comb begin
      query_body = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < length) && (seg_x[i] == query_x) && (seg_y[i] == query_y))
            query_body = 1'b1;
      end
   end

   assign query_head = (seg_x[0] == query_x) && (seg_y[0] == query_y);
   assign head_x     = seg_x[0];
   assign head_y     = seg_y[0];

   assign move_now = is_running && !hit_boundary && !hit_self && (move_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= init_y(i);
         end
         length       <= LEN_INIT;
         dir          <= DIR_RIGHT;
         pending_dir  <= DIR_RIGHT;
         move_cnt     <= '0;
         grow_pending <= 1'b0;
         move_tick    <= 1'b0;
         hit_boundary <= 1'b0;
         hit_self     <= 1'b0;
      end else if (is_initial) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= init_y(i);
         end
         length       <= LEN_INIT;
         dir          <= DIR_RIGHT;
         pending_dir  <= req_valid ? req_dir : DIR_RIGHT;
         move_cnt     <= '0;
         grow_pending <= 1'b0;
         move_tick    <= 1'b0;
         hit_boundary <= 1'b0;
         hit_self     <= 1'b0;
      end else begin
         move_tick <= 1'b0;
         if (grow)
            grow_pending <= 1'b1;
         if (is_running && req_valid)
            pending_dir <= req_dir;

         if (is_running && !hit_boundary && !hit_self) begin
            if (move_now) begin
               move_cnt  <= '0;
               move_tick <= 1'b1;
               dir       <= pending_dir;
               if (edge_hit) begin
                  hit_boundary <= 1'b1;
               end else if (body_hit) begin
                  hit_self <= 1'b1;
               end else begin
                  for (int i = MAX_LEN - 1; i > 0; i--) begin
                     seg_x[i] <= seg_x[i-1];
                     seg_y[i] <= seg_y[i-1];
                  end
                  seg_x[0] <= nxt_x;
                  seg_y[0] <= nxt_y;
                  if (grow_pending) begin
                     if (length != LEN_MAX)
                        length <= length + 1'b1;
                     // A grow arriving in this cycle is new food; keep it.
                     grow_pending <= grow;
                  end
               end
            end else begin
               move_cnt <= move_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_snake_engine.sv
module tb_snake_engine;

   localparam int MOVE_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] game_state;
   logic       up, down, left, right, grow;
   logic [5:0] query_x;
   logic [4:0] query_y;
   logic       query_body, query_head;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic [4:0] length;
   logic       move_tick, hit_boundary, hit_self;

   int n_checks = 0;
   int n_fail   = 0;

   snake_engine #(.MOVE_DIV(MOVE_DIV)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .game_state   (game_state),
      .up           (up),
      .down         (down),
      .left         (left),
      .right        (right),
      .grow         (grow),
      .query_x      (query_x),
      .query_y      (query_y),
      .query_body   (query_body),
      .query_head   (query_head),
      .head_x       (head_x),
      .head_y       (head_y),
      .length       (length),
      .move_tick    (move_tick),
      .hit_boundary (hit_boundary),
      .hit_self     (hit_self)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0] gs;
      logic [3:0] btn;   // {up, down, left, right}
      logic       grw;
      int         moves;
      int         hx;
      int         hy;
      int         len;
      logic       hb;
      logic       hs;
   } vec_t;

   vec_t vecs[30];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_moves(input int n, input string tag);
      int cyc;
      for (int m = 0; m < n; m++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!move_tick && cyc < 10 * MOVE_DIV);
         if (!move_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no move_tick within %0d cycles", tag, cyc);
            return;
         end
      end
   endtask

   task automatic check_query(input string name, input int qx, input int qy,
                              input int exp_body, input int exp_head);
      query_x = 6'(qx);
      query_y = 5'(qy);
      #1;
      check({name, " body"}, int'(query_body), exp_body);
      check({name, " head"}, int'(query_head), exp_head);
   endtask

   task automatic check_layout(input string name);
      check({name, " head_x"}, int'(head_x), 20);
      check({name, " head_y"}, int'(head_y), 15);
      check({name, " length"}, int'(length), 3);
      check({name, " hit_boundary"}, int'(hit_boundary), 0);
      check({name, " hit_self"}, int'(hit_self), 0);
   endtask

   initial begin
      int cyc;
      int ticks;
      int exp_hx, exp_hy, exp_len;

      vecs[0]  = '{2'b10, 4'b0000, 1'b0, 0, 20, 15, 3, 1'b0, 1'b0};
      vecs[1]  = '{2'b00, 4'b0000, 1'b0, 1, 21, 15, 3, 1'b0, 1'b0};
      vecs[2]  = '{2'b00, 4'b0000, 1'b0, 1, 22, 15, 3, 1'b0, 1'b0};
      vecs[3]  = '{2'b00, 4'b0000, 1'b0, 1, 23, 15, 3, 1'b0, 1'b0};
      vecs[4]  = '{2'b00, 4'b0010, 1'b0, 1, 24, 15, 3, 1'b0, 1'b0};
      vecs[5]  = '{2'b00, 4'b1000, 1'b0, 1, 24, 14, 3, 1'b0, 1'b0};
      vecs[6]  = '{2'b00, 4'b0000, 1'b0, 1, 24, 13, 3, 1'b0, 1'b0};
      vecs[7]  = '{2'b00, 4'b0100, 1'b0, 1, 24, 12, 3, 1'b0, 1'b0};
      vecs[8]  = '{2'b00, 4'b0110, 1'b0, 1, 24, 11, 3, 1'b0, 1'b0};
      vecs[9]  = '{2'b00, 4'b0011, 1'b0, 1, 23, 11, 3, 1'b0, 1'b0};
      vecs[10] = '{2'b10, 4'b0000, 1'b0, 0, 20, 15, 3, 1'b0, 1'b0};
      vecs[11] = '{2'b00, 4'b0000, 1'b1, 1, 21, 15, 4, 1'b0, 1'b0};
      vecs[12] = '{2'b00, 4'b0000, 1'b1, 1, 22, 15, 5, 1'b0, 1'b0};
      vecs[13] = '{2'b00, 4'b1000, 1'b0, 1, 22, 14, 5, 1'b0, 1'b0};
      vecs[14] = '{2'b00, 4'b0010, 1'b0, 1, 21, 14, 5, 1'b0, 1'b0};
      vecs[15] = '{2'b00, 4'b0100, 1'b0, 1, 21, 14, 5, 1'b0, 1'b1};
      vecs[16] = '{2'b10, 4'b0000, 1'b0, 0, 20, 15, 3, 1'b0, 1'b0};
      vecs[17] = '{2'b00, 4'b0000, 1'b1, 1, 21, 15, 4, 1'b0, 1'b0};
      vecs[18] = '{2'b00, 4'b1000, 1'b0, 1, 21, 14, 4, 1'b0, 1'b0};
      vecs[19] = '{2'b00, 4'b0010, 1'b0, 1, 20, 14, 4, 1'b0, 1'b0};
      vecs[20] = '{2'b00, 4'b0100, 1'b0, 1, 20, 15, 4, 1'b0, 1'b0};
      vecs[21] = '{2'b00, 4'b0001, 1'b0, 1, 21, 15, 4, 1'b0, 1'b0};
      vecs[22] = '{2'b00, 4'b1000, 1'b0, 1, 21, 14, 4, 1'b0, 1'b0};
      vecs[23] = '{2'b10, 4'b0000, 1'b0, 0, 20, 15, 3, 1'b0, 1'b0};
      vecs[24] = '{2'b00, 4'b0000, 1'b0, 1, 21, 15, 3, 1'b0, 1'b0};
      vecs[25] = '{2'b01, 4'b0000, 1'b1, 0, 21, 15, 3, 1'b0, 1'b0};
      vecs[26] = '{2'b00, 4'b0000, 1'b0, 1, 22, 15, 4, 1'b0, 1'b0};
      vecs[27] = '{2'b11, 4'b0000, 1'b1, 0, 22, 15, 4, 1'b0, 1'b0};
      vecs[28] = '{2'b10, 4'b0000, 1'b0, 0, 20, 15, 3, 1'b0, 1'b0};
      vecs[29] = '{2'b00, 4'b0000, 1'b0, 1, 21, 15, 3, 1'b0, 1'b0};

      rst_n = 1'b0;
      game_state = 2'b00;
      {up, down, left, right} = 4'b0000;
      grow = 1'b0;
      query_x = '0;
      query_y = '0;

      // Reset state
      #12;
      check_layout("reset");
      check("reset move_tick", int'(move_tick), 0);
      check_query("reset q(19,15)", 19, 15, 1, 0);
      check_query("reset q(18,15)", 18, 15, 1, 0);
      check_query("reset q(20,15)", 20, 15, 1, 1);
      check_query("reset q(17,15)", 17, 15, 0, 0);
      check_query("reset q(0,0)", 0, 0, 0, 0);

      @(negedge clk);
      rst_n = 1'b1;

      // Move period and first moves
      wait_moves(1, "first move");
      check("first head_x", int'(head_x), 21);
      check_query("after move q(18,15)", 18, 15, 0, 0);
      check_query("after move q(21,15)", 21, 15, 1, 1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!move_tick && cyc < 20);
      check("tick period", cyc, MOVE_DIV);
      check("second head_x", int'(head_x), 22);
      check_query("second q(19,15)", 19, 15, 0, 0);
      check_query("second q(20,15)", 20, 15, 1, 0);

      // Asynchronous reset mid-cycle, away from any edge
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_layout("async reset");
      check("async reset move_tick", int'(move_tick), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int v = 0; v < 30; v++) begin
         game_state = vecs[v].gs;
         {up, down, left, right} = vecs[v].btn;
         grow = vecs[v].grw;
         @(negedge clk);
         {up, down, left, right} = 4'b0000;
         grow = 1'b0;
         wait_moves(vecs[v].moves, $sformatf("vec%0d", v));
         check($sformatf("vec%0d head_x", v), int'(head_x), vecs[v].hx);
         check($sformatf("vec%0d head_y", v), int'(head_y), vecs[v].hy);
         check($sformatf("vec%0d length", v), int'(length), vecs[v].len);
         check($sformatf("vec%0d hit_boundary", v), int'(hit_boundary), int'(vecs[v].hb));
         check($sformatf("vec%0d hit_self", v), int'(hit_self), int'(vecs[v].hs));
      end
      check_query("stale q(0,0)", 0, 0, 0, 0);

      // Run into the right edge, then freeze in RUNNING and DIE
      game_state = 2'b10;
      @(negedge clk);
      game_state = 2'b00;
      wait_moves(19, "run right");
      check("edge head_x", int'(head_x), 39);
      check("edge hit_boundary", int'(hit_boundary), 0);
      wait_moves(1, "edge move");
      check("boundary flag", int'(hit_boundary), 1);
      check("boundary hit_self", int'(hit_self), 0);
      check("boundary head_x", int'(head_x), 39);
      check("boundary head_y", int'(head_y), 15);
      ticks = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (move_tick) ticks++;
      end
      check("post-hit running ticks", ticks, 0);
      check("post-hit head_x", int'(head_x), 39);
      ticks = 0;
      for (int c = 0; c < 10; c++) begin
         game_state = (c < 6) ? 2'b01 : 2'b11;
         grow = (c == 3);
         {up, down, left, right} = 4'b1000;
         @(negedge clk);
         if (move_tick) ticks++;
      end
      grow = 1'b0;
      {up, down, left, right} = 4'b0000;
      check("die ticks", ticks, 0);
      check("die head_x", int'(head_x), 39);
      check("die head_y", int'(head_y), 15);
      check("die length", int'(length), 3);
      check("die hit_boundary", int'(hit_boundary), 1);
      game_state = 2'b10;
      @(negedge clk);
      check_layout("restore");

      // Growth saturates at 16; last turn goes up
      for (int k = 1; k <= 20; k++) begin
         game_state = 2'b00;
         grow = 1'b1;
         up = (k == 16);
         @(negedge clk);
         grow = 1'b0;
         up = 1'b0;
         wait_moves(1, $sformatf("grow%0d", k));
         exp_len = (3 + k > 16) ? 16 : 3 + k;
         exp_hx  = (k <= 15) ? 20 + k : 35;
         exp_hy  = (k <= 15) ? 15 : 15 - (k - 15);
         check($sformatf("grow%0d length", k), int'(length), exp_len);
         check($sformatf("grow%0d head_x", k), int'(head_x), exp_hx);
         check($sformatf("grow%0d head_y", k), int'(head_y), exp_hy);
      end
      check("full hit_self", int'(hit_self), 0);
      check_query("full q(35,10)", 35, 10, 1, 1);
      check_query("full q(35,15)", 35, 15, 1, 0);
      check_query("full q(25,15)", 25, 15, 1, 0);
      check_query("full q(24,15)", 24, 15, 0, 0);
      check_query("full q(36,10)", 36, 10, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
